// File: rtl/led_frame_scheduler.sv
// ---------------------------------------------------------------------------
// led_frame_scheduler
//
// Purpose:
//    Streams one frame of 24-bit GRB pixels, MSB first, to a serial LED bit
//    transmitter. Pixels are fetched from an external buffer that has a
//    one-cycle registered read. While one pixel is being shifted out, the
//    next pixel is prefetched into a hold register, so the transmitter never
//    waits at a pixel boundary. After the last bit, all_bits_shifted is held
//    high for LATCH_CYCLES clocks. frame_done then pulses for one cycle.
//
// Parameters:
//    NUM_LEDS      pixels per frame (1..1023)
//    LATCH_CYCLES  clocks all_bits_shifted stays high after the last bit (>=2)
//    ADDR_W        pixel buffer address width
//
// Ports:
//    clk               single clock, rising edge
//    rst               asynchronous, active-high reset
//    frame_start       one-cycle request to send a frame (ignored while busy)
//    pix_rd_en         pixel buffer read strobe
//    pix_addr          pixel buffer read address
//    pix_data          GRB pixel word, valid the cycle after pix_rd_en
//    new_bit_rqst      one-cycle pulse from the transmitter: present next bit
//    bit_to_transmit   current bit for the transmitter
//    all_bits_shifted  high during the latch/reset period
//    busy              high whenever the FSM is not idle
//    frame_done        one-cycle pulse at the end of the latch period
//
// Build option:
//    LED_AUTO_REFRESH_EN  when defined, the end of the latch period restarts
//                         a new frame directly (PREFETCH) without frame_start.
//                         frame_done still pulses.
// ---------------------------------------------------------------------------
module led_frame_scheduler #(
   parameter int NUM_LEDS     = 64,
   parameter int LATCH_CYCLES = 4000,
   parameter int ADDR_W       = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   output logic              pix_rd_en,
   output logic [ADDR_W-1:0] pix_addr,
   input  logic [23:0]       pix_data,
   input  logic              new_bit_rqst,
   output logic              bit_to_transmit,
   output logic              all_bits_shifted,
   output logic              busy,
   output logic              frame_done
);

   localparam int                LAT_W    = $clog2(LATCH_CYCLES + 1);
   localparam logic [LAT_W-1:0]  LAT_END  = LAT_W'(LATCH_CYCLES);
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_LEDS - 1);
   localparam logic [ADDR_W:0]   NUM_PIX  = (ADDR_W + 1)'(NUM_LEDS);

   typedef enum logic [2:0] {
      IDLE,
      PREFETCH,
      LOAD,
      SHIFT,
      LATCH
   } state_t;

   state_t            state_q,      state_d;
   logic [23:0]       shift_q,      shift_d;
   logic [4:0]        bit_idx_q,    bit_idx_d;
   logic [23:0]       hold_q,       hold_d;
   logic              hold_valid_q, hold_valid_d;
   logic              hold_cap_q,   hold_cap_d;
   logic [ADDR_W-1:0] pix_cnt_q,    pix_cnt_d;
   logic [ADDR_W-1:0] addr_q,       addr_d;
   logic              rd_en_q,      rd_en_d;
   logic [LAT_W-1:0]  lat_cnt_q,    lat_cnt_d;

   // Address of the read issued at the next pixel boundary. The pixel being
   // shifted is pix_cnt_q and the hold register already has pix_cnt_q+1, so
   // the refill read targets pix_cnt_q+2. One extra bit keeps the compare
   // against NUM_LEDS free of wrap-around.
   logic [ADDR_W:0]   next_rd;
   logic              more_reads;

   assign next_rd    = {1'b0, pix_cnt_q} + (ADDR_W + 1)'(2);
   assign more_reads = (next_rd < NUM_PIX);

   assign pix_rd_en  = rd_en_q;
   assign pix_addr   = addr_q;
   assign busy       = (state_q != IDLE);

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d          = state_q;
      shift_d          = shift_q;
      bit_idx_d        = bit_idx_q;
      hold_d           = hold_q;
      hold_valid_d     = hold_valid_q;
      pix_cnt_d        = pix_cnt_q;
      addr_d           = addr_q;
      rd_en_d          = 1'b0;
      lat_cnt_d        = lat_cnt_q;
      bit_to_transmit  = 1'b0;
      all_bits_shifted = 1'b0;
      frame_done       = 1'b0;

      // A read strobed while in LOAD or SHIFT returns data on the following
      // cycle; that word is destined for the hold register. The address-0
      // read (strobed in PREFETCH) goes straight into the shift register
      // in LOAD and is excluded here.
      hold_cap_d = rd_en_q && ((state_q == LOAD) || (state_q == SHIFT));
      if (hold_cap_q) begin
         hold_d       = pix_data;
         hold_valid_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d      = PREFETCH;
               rd_en_d      = 1'b1;
               addr_d       = '0;
               pix_cnt_d    = '0;
               hold_valid_d = 1'b0;
            end
         end

         PREFETCH: begin
            // Buffer is returning pixel 0 during the next cycle (LOAD).
            // Queue the pixel-1 read so it is in flight at the same time.
            state_d = LOAD;
            if (NUM_LEDS > 1) begin
               rd_en_d = 1'b1;
               addr_d  = ADDR_W'(1);
            end
         end

         LOAD: begin
            shift_d   = pix_data;
            bit_idx_d = 5'd23;
            state_d   = SHIFT;
         end

         SHIFT: begin
            bit_to_transmit = shift_q[23];
            if (new_bit_rqst) begin
               if (bit_idx_q != 5'd0) begin
                  shift_d   = {shift_q[22:0], 1'b0};
                  bit_idx_d = bit_idx_q - 5'd1;
               end else if (pix_cnt_q == LAST_PIX) begin
                  state_d   = LATCH;
                  lat_cnt_d = '0;
               end else begin
                  shift_d      = hold_q;
                  bit_idx_d    = 5'd23;
                  hold_valid_d = 1'b0;
                  pix_cnt_d    = pix_cnt_q + 1'b1;
                  if (more_reads) begin
                     rd_en_d = 1'b1;
                     addr_d  = next_rd[ADDR_W-1:0];
                  end
               end
            end
         end

         LATCH: begin
            // lat_cnt_q runs 0..LATCH_CYCLES-1 with all_bits_shifted high.
            // The cycle with lat_cnt_q == LATCH_CYCLES carries frame_done
            // while still in LATCH, so a coincident frame_start is ignored.
            if (lat_cnt_q == LAT_END) begin
               frame_done = 1'b1;
               lat_cnt_d  = '0;
`ifdef LED_AUTO_REFRESH_EN
               state_d      = PREFETCH;
               rd_en_d      = 1'b1;
               addr_d       = '0;
               pix_cnt_d    = '0;
               hold_valid_d = 1'b0;
`else
               state_d = IDLE;
`endif
            end else begin
               all_bits_shifted = 1'b1;
               lat_cnt_d        = lat_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         bit_idx_q    <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         hold_cap_q   <= 1'b0;
         pix_cnt_q    <= '0;
         addr_q       <= '0;
         rd_en_q      <= 1'b0;
         lat_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_idx_q    <= bit_idx_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         hold_cap_q   <= hold_cap_d;
         pix_cnt_q    <= pix_cnt_d;
         addr_q       <= addr_d;
         rd_en_q      <= rd_en_d;
         lat_cnt_q    <= lat_cnt_d;
      end
   end

endmodule
